// File: rtl/sort_sequencer_if.sv
// ---------------------------------------------------------------------------
// sort_sequencer_if
// Groups the colour handshake and the motor/status outputs of sort_sequencer.
//   colour[5:0]   one-hot colour (red, brown, yellow, orange, blue, green)
//   colour_valid  colour is valid this cycle
//   colour_ready  sequencer can accept a colour
//   GPIO_1[3:0]   platform stepper coil drive
//   latch_open    high opens the latch
//   busy          a sort cycle is in progress
//   done          one-cycle pulse when the platform is back home
//   err           one-cycle pulse on an accepted colour that is not one-hot
//   sort_count    (SORT_STATS_EN only) saturating count of completed sorts
// Modports: master = colour source / status observer, slave = sequencer.
// ---------------------------------------------------------------------------
interface sort_sequencer_if;
    logic [5:0]  colour;
    logic        colour_valid;
    logic        colour_ready;
    logic [3:0]  GPIO_1;
    logic        latch_open;
    logic        busy;
    logic        done;
    logic        err;
`ifdef SORT_STATS_EN
    logic [15:0] sort_count;
`endif

    modport master (
        output colour,
        output colour_valid,
        input  colour_ready,
        input  GPIO_1,
        input  latch_open,
        input  busy,
        input  done,
        input  err
`ifdef SORT_STATS_EN
        , input sort_count
`endif
    );

    modport slave (
        input  colour,
        input  colour_valid,
        output colour_ready,
        output GPIO_1,
        output latch_open,
        output busy,
        output done,
        output err
`ifdef SORT_STATS_EN
        , output sort_count
`endif
    );
endinterface

// File: rtl/sort_sequencer.sv
// ---------------------------------------------------------------------------
// sort_sequencer
// Runs one M&M sort cycle: accept a one-hot colour, step the platform to the
// colour's bin, settle, open the latch, step back home, pulse done.
//
// Ports:
//   clk    system clock (50 MHz nominal)
//   rst_n  asynchronous active-low reset
//   bus    sort_sequencer_if.slave (colour handshake, coils, latch, status)
//
// Parameters:
//   STEP_DIV    clock cycles per coil phase step
//   STEPS_REV   phase steps per platform revolution (multiple of 8, >= 8)
//   SETTLE_CYC  hold cycles at the bin before the latch opens
//   LATCH_CYC   cycles latch_open is held high
//
// Optional feature (macro SORT_STATS_EN): adds bus.sort_count, a 16-bit
// saturating count of done pulses. Without the macro the counter is absent.
// ---------------------------------------------------------------------------
module sort_sequencer #(
    parameter int unsigned STEP_DIV   = 97_656,
    parameter int unsigned STEPS_REV  = 512,
    parameter int unsigned SETTLE_CYC = 2_500_000,
    parameter int unsigned LATCH_CYC  = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    sort_sequencer_if.slave  bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MOVE_OUT  = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_DROP      = 3'd3;
    localparam logic [2:0] ST_MOVE_BACK = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // Bin targets are fixed multiples of an eighth of a revolution, so they
    // are resolved at elaboration time.
    localparam logic [31:0] TGT_1 = 32'(STEPS_REV / 8 * 1);
    localparam logic [31:0] TGT_2 = 32'(STEPS_REV / 8 * 2);
    localparam logic [31:0] TGT_3 = 32'(STEPS_REV / 8 * 3);
    localparam logic [31:0] TGT_4 = 32'(STEPS_REV / 8 * 4);

    localparam logic [31:0] STEP_LAST   = 32'(STEP_DIV - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] LATCH_LAST  = 32'(LATCH_CYC - 1);

    logic [2:0]  state_reg,      state_next;
    logic [1:0]  phase_reg,      phase_next;
    logic [31:0] step_tmr_reg,   step_tmr_next;
    logic [31:0] steps_left_reg, steps_left_next;
    logic [31:0] hold_tmr_reg,   hold_tmr_next;
    logic [31:0] target_reg,     target_next;
    logic        dir_cw_reg,     dir_cw_next;
    logic        err_reg,        err_next;

    logic        accept;
    logic        dec_valid;
    logic [31:0] dec_target;
    logic        dec_cw;
    logic        coil_en;

    // Colour decode: anything other than exactly one set bit is invalid.
    always_comb begin
        dec_valid  = 1'b1;
        dec_target = 32'd0;
        dec_cw     = 1'b1;
        case (bus.colour)
            6'b000001: dec_target = TGT_1;                     // red
            6'b000010: dec_target = TGT_2;                     // brown
            6'b000100: dec_target = TGT_3;                     // yellow
            6'b001000: dec_target = TGT_4;                     // orange
            6'b010000: begin dec_target = TGT_2; dec_cw = 1'b0; end // blue
            6'b100000: begin dec_target = TGT_3; dec_cw = 1'b0; end // green
            default:   dec_valid = 1'b0;
        endcase
    end

    assign accept = bus.colour_valid && (state_reg == ST_IDLE);

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        step_tmr_next   = step_tmr_reg;
        steps_left_next = steps_left_reg;
        hold_tmr_next   = hold_tmr_reg;
        target_next     = target_reg;
        dir_cw_next     = dir_cw_reg;
        err_next        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_valid) begin
                        target_next     = dec_target;
                        dir_cw_next     = dec_cw;
                        steps_left_next = dec_target;
                        step_tmr_next   = 32'd0;
                        state_next      = ST_MOVE_OUT;
                    end else begin
                        // Bad colour is consumed without motion.
                        err_next = 1'b1;
                    end
                end
            end

            ST_MOVE_OUT, ST_MOVE_BACK: begin
                if (step_tmr_reg == STEP_LAST) begin
                    step_tmr_next   = 32'd0;
                    phase_next      = dir_cw_reg ? phase_reg + 2'd1 : phase_reg - 2'd1;
                    steps_left_next = steps_left_reg - 32'd1;
                    if (steps_left_reg == 32'd1) begin
                        hold_tmr_next = 32'd0;
                        state_next    = (state_reg == ST_MOVE_OUT) ? ST_SETTLE : ST_DONE;
                    end
                end else begin
                    step_tmr_next = step_tmr_reg + 32'd1;
                end
            end

            ST_SETTLE: begin
                if (hold_tmr_reg == SETTLE_LAST) begin
                    hold_tmr_next = 32'd0;
                    state_next    = ST_DROP;
                end else begin
                    hold_tmr_next = hold_tmr_reg + 32'd1;
                end
            end

            ST_DROP: begin
                if (hold_tmr_reg == LATCH_LAST) begin
                    // Retrace the same number of steps the other way so the
                    // platform ends on the phase it started from.
                    hold_tmr_next   = 32'd0;
                    steps_left_next = target_reg;
                    dir_cw_next     = !dir_cw_reg;
                    step_tmr_next   = 32'd0;
                    state_next      = ST_MOVE_BACK;
                end else begin
                    hold_tmr_next = hold_tmr_reg + 32'd1;
                end
            end

            ST_DONE: state_next = ST_IDLE;

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            phase_reg      <= 2'd0;
            step_tmr_reg   <= 32'd0;
            steps_left_reg <= 32'd0;
            hold_tmr_reg   <= 32'd0;
            target_reg     <= 32'd0;
            dir_cw_reg     <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            step_tmr_reg   <= step_tmr_next;
            steps_left_reg <= steps_left_next;
            hold_tmr_reg   <= hold_tmr_next;
            target_reg     <= target_next;
            dir_cw_reg     <= dir_cw_next;
            err_reg        <= err_next;
        end
    end

    // Outputs decode straight from the asynchronously reset state, so the
    // coils and latch drop the instant rst_n falls.
    assign coil_en = (state_reg == ST_MOVE_OUT) || (state_reg == ST_SETTLE) ||
                     (state_reg == ST_DROP)     || (state_reg == ST_MOVE_BACK);

    // Phase 0 energises GPIO_1[3], phase 3 energises GPIO_1[0].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_coil
            assign bus.GPIO_1[gi] = coil_en && (phase_reg == 2'(3 - gi));
        end
    endgenerate

    assign bus.colour_ready = (state_reg == ST_IDLE);
    assign bus.busy         = coil_en;
    assign bus.latch_open   = (state_reg == ST_DROP);
    assign bus.done         = (state_reg == ST_DONE);
    assign bus.err          = err_reg;

`ifdef SORT_STATS_EN
    logic [15:0] sort_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sort_count_reg <= 16'd0;
        end else if ((state_reg == ST_DONE) && (sort_count_reg != 16'hFFFF)) begin
            sort_count_reg <= sort_count_reg + 16'd1;
        end
    end

    assign bus.sort_count = sort_count_reg;
`endif

endmodule

// File: tb/tb_sort_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sort_sequencer
// Directed and randomized sort cycles compared cycle by cycle against a
// timeline built from the sequencing rules (steps, settle, drop, return).
// ---------------------------------------------------------------------------
module tb_sort_sequencer;

    localparam int STEP_DIV   = 4;
    localparam int STEPS_REV  = 16;
    localparam int SETTLE_CYC = 3;
    localparam int LATCH_CYC  = 5;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;
    int model_phase = 0;
    int stats_model = 0;
    int txn_no = 0;

    logic [8:0] exp_q[$];

    sort_sequencer_if bus();

    sort_sequencer #(
        .STEP_DIV  (STEP_DIV),
        .STEPS_REV (STEPS_REV),
        .SETTLE_CYC(SETTLE_CYC),
        .LATCH_CYC (LATCH_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // {GPIO_1, latch_open, busy, done, err, colour_ready}
    function automatic logic [8:0] mk(input logic [3:0] g, input logic l, input logic b,
                                      input logic d, input logic e, input logic r);
        return {g, l, b, d, e, r};
    endfunction

    function automatic logic [8:0] obs_word();
        return {bus.GPIO_1, bus.latch_open, bus.busy, bus.done, bus.err, bus.colour_ready};
    endfunction

    function automatic logic [3:0] pat(input int p);
        logic [3:0] base;
        base = 4'b1000;
        return base >> p;
    endfunction

    // Expected per-cycle outputs for the cycles following an accept of c.
    task automatic build_expected(input logic [5:0] c);
        int k_tbl[6] = '{1, 2, 3, 4, 2, 3};
        int d_tbl[6] = '{1, 1, 1, 1, -1, -1};
        int ones = 0;
        int idx = 0;
        int steps, d, p;
        exp_q.delete();
        for (int i = 0; i < 6; i++) if (c[i]) begin ones++; idx = i; end
        if (ones != 1) begin
            exp_q.push_back(mk(4'b0000, 0, 0, 0, 1, 1));
            exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 1));
            return;
        end
        steps = STEPS_REV * k_tbl[idx] / 8;
        d = d_tbl[idx];
        p = model_phase;
        for (int s = 0; s < steps; s++) begin
            for (int t = 0; t < STEP_DIV; t++) exp_q.push_back(mk(pat(p), 0, 1, 0, 0, 0));
            p = (p + d + 4) % 4;
        end
        for (int t = 0; t < SETTLE_CYC; t++) exp_q.push_back(mk(pat(p), 0, 1, 0, 0, 0));
        for (int t = 0; t < LATCH_CYC; t++)  exp_q.push_back(mk(pat(p), 1, 1, 0, 0, 0));
        for (int s = 0; s < steps; s++) begin
            for (int t = 0; t < STEP_DIV; t++) exp_q.push_back(mk(pat(p), 0, 1, 0, 0, 0));
            p = (p - d + 4) % 4;
        end
        exp_q.push_back(mk(4'b0000, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 1));
        model_phase = p;
        if (stats_model < 16'hFFFF) stats_model++;
    endtask

    // Called on a negedge: present a colour for acceptance at the next posedge.
    task automatic offer(input logic [5:0] c);
        bus.colour       = c;
        bus.colour_valid = 1'b1;
        check("ready_pre", 32'(bus.colour_ready), 32'd1);
    endtask

    // Follows one accepted colour through to the first IDLE cycle after it.
    task automatic track(input logic [5:0] c, input bit keep_valid,
                         input logic [5:0] next_c, input string name);
        int n;
        build_expected(c);
        n = exp_q.size();
        @(posedge clk);
        @(negedge clk);
        if (keep_valid) bus.colour = next_c;
        else            bus.colour_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_c%0d", name, i + 1), 32'(obs_word()), 32'(exp_q[i]));
            if (i < n - 1) @(negedge clk);
        end
`ifdef SORT_STATS_EN
        check($sformatf("%s_count", name), 32'(bus.sort_count), 32'(stats_model));
`endif
        txn_no++;
        $display("txn %0d %s colour=%b cycles=%0d phase=%0d", txn_no, name, c, n, model_phase);
    endtask

    initial begin
        int guard;
        int gap;
        logic [5:0] c;

        rst_n            = 1'b0;
        bus.colour       = 6'd0;
        bus.colour_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(obs_word()), 32'(mk(4'b0000, 0, 0, 0, 0, 1)));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(obs_word()), 32'(mk(4'b0000, 0, 0, 0, 0, 1)));

        // Directed cases
        offer(6'b000001); track(6'b000001, 0, 6'd0, "red");
        offer(6'b100000); track(6'b100000, 0, 6'd0, "green");
        offer(6'b000011); track(6'b000011, 0, 6'd0, "invalid");
        offer(6'b001000); track(6'b001000, 1, 6'b010000, "orange_hold");
        track(6'b010000, 0, 6'd0, "blue_after");

        // Reset while the latch is open
        offer(6'b000001);
        @(posedge clk);
        @(negedge clk);
        bus.colour_valid = 1'b0;
        guard = 0;
        while (!bus.latch_open && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drop_reached", 32'(bus.latch_open), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_gpio", 32'(bus.GPIO_1), 32'd0);
        check("rst_latch", 32'(bus.latch_open), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_phase = 0;
        stats_model = 0;
        @(negedge clk);
        check("rst_idle", 32'(obs_word()), 32'(mk(4'b0000, 0, 0, 0, 0, 1)));
        $display("txn %0d reset_in_drop", ++txn_no);
        offer(6'b000001); track(6'b000001, 0, 6'd0, "red_post_rst");

        // Randomized cycles with idle gaps
        for (int n = 0; n < 16; n++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("gap_idle", 32'(obs_word()), 32'(mk(4'b0000, 0, 0, 0, 0, 1)));
            end
            if ($urandom_range(0, 4) == 0) c = 6'($urandom_range(0, 63));
            else                           c = 6'(1 << $urandom_range(0, 5));
            offer(c);
            track(c, 0, 6'd0, "rnd");
        end

`ifdef SORT_STATS_EN
        force dut.sort_count_reg = 16'hFFFF;
        @(negedge clk);
        release dut.sort_count_reg;
        stats_model = 16'hFFFF;
        offer(6'b000010); track(6'b000010, 0, 6'd0, "saturate");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
